// File: rtl/poly_mac_engine.sv
// Self-sequenced schoolbook polynomial multiplier r = a*b over signed coefficients,
// with result-RAM clearing and optional in-place fold modulo x^P - x - 1.
module poly_mac_engine #(
    parameter int P      = 757,
    parameter int CW     = 13,
    parameter int AW     = 26,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              reduce,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] out_len,
    output logic [ADDR_W-1:0] a_addr,
    input  logic [CW-1:0]     a_data,
    output logic [ADDR_W-1:0] b_addr,
    input  logic [CW-1:0]     b_data,
    output logic [ADDR_W-1:0] r_raddr,
    input  logic [AW-1:0]     r_rdata,
    output logic [ADDR_W-1:0] r_waddr,
    output logic [AW-1:0]     r_wdata,
    output logic              r_we
);
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_COEF = ADDR_W'(P - 1);
    localparam logic [ADDR_W-1:0] LAST_PROD = ADDR_W'(2 * P - 2);
    localparam logic [ADDR_W-1:0] LEN_FULL  = ADDR_W'(2 * P - 1);
    localparam logic [ADDR_W-1:0] LEN_RED   = ADDR_W'(P);

    typedef enum logic [3:0] {
        IDLE, CLEAR, MAC, DRAIN, F_RD, F_CAP, F_LO, F_HI, DONE
    } state_t;

    state_t                  state;
    logic                    reduce_q;
    logic                    mac_wr;
    logic                    fold_wr;
    logic                    fwd;
    logic [ADDR_W-1:0]       fold_k;
    logic [AW-1:0]           wdata_q;
    logic [AW-1:0]           fold_v;
    logic [AW-1:0]           r_cur;
    logic [AW-1:0]           prod_ext;
    logic signed [2*CW-1:0]  prod;

    // RAM data arrives during the write cycle, so write data cannot be registered;
    // fwd covers the read-first RAM returning a value being overwritten that cycle.
    always_comb begin
        prod     = (2*CW)'($signed(a_data)) * (2*CW)'($signed(b_data));
        prod_ext = AW'(prod);
        r_cur    = fwd ? wdata_q : r_rdata;
        r_wdata  = '0;
        if (mac_wr)
            r_wdata = r_cur + prod_ext;
        else if (fold_wr)
            r_wdata = r_cur + fold_v;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            out_len  <= '0;
            a_addr   <= '0;
            b_addr   <= '0;
            r_raddr  <= '0;
            r_waddr  <= '0;
            r_we     <= 1'b0;
            reduce_q <= 1'b0;
            mac_wr   <= 1'b0;
            fold_wr  <= 1'b0;
            fwd      <= 1'b0;
            wdata_q  <= '0;
            fold_v   <= '0;
            fold_k   <= '0;
        end else begin
            fwd     <= r_we && (r_raddr == r_waddr);
            wdata_q <= r_wdata;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= CLEAR;
                        busy     <= 1'b1;
                        reduce_q <= reduce;
                        out_len  <= reduce ? LEN_RED : LEN_FULL;
                        r_we     <= 1'b1;
                        r_waddr  <= '0;
                    end
                end
                CLEAR: begin
                    if (r_waddr == LAST_PROD) begin
                        state   <= MAC;
                        r_we    <= 1'b0;
                        a_addr  <= '0;
                        b_addr  <= '0;
                        r_raddr <= '0;
                    end else begin
                        r_waddr <= r_waddr + ONE;
                    end
                end
                // Each cycle retires the previous issue's write and issues the next (i, j).
                MAC: begin
                    r_we    <= 1'b1;
                    mac_wr  <= 1'b1;
                    r_waddr <= r_raddr;
                    if (b_addr == LAST_COEF) begin
                        if (a_addr == LAST_COEF) begin
                            state <= DRAIN;
                        end else begin
                            a_addr  <= a_addr + ONE;
                            b_addr  <= '0;
                            r_raddr <= a_addr + ONE;
                        end
                    end else begin
                        b_addr  <= b_addr + ONE;
                        r_raddr <= r_raddr + ONE;
                    end
                end
                DRAIN: begin
                    r_we   <= 1'b0;
                    mac_wr <= 1'b0;
                    if (reduce_q) begin
                        state   <= F_RD;
                        fold_k  <= LAST_PROD;
                        r_raddr <= LAST_PROD;
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                F_RD: begin
                    state   <= F_CAP;
                    r_raddr <= fold_k - LEN_RED;
                end
                F_CAP: begin
                    state   <= F_LO;
                    fold_v  <= r_cur;
                    r_raddr <= fold_k - LEN_RED + ONE;
                    r_waddr <= fold_k - LEN_RED;
                    r_we    <= 1'b1;
                    fold_wr <= 1'b1;
                end
                F_LO: begin
                    state   <= F_HI;
                    r_waddr <= r_waddr + ONE;
                end
                F_HI: begin
                    r_we    <= 1'b0;
                    fold_wr <= 1'b0;
                    if (fold_k == LEN_RED) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state   <= F_RD;
                        fold_k  <= fold_k - ONE;
                        r_raddr <= fold_k - ONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_poly_mac_engine.sv
// Scoreboard bench for poly_mac_engine: instance 0 uses P=4, instance 1 uses P=2
// (P=2 makes consecutive MAC issues hit the same result address).
module tb_poly_mac_engine;
    localparam int CW = 13;
    localparam int AW = 26;
    localparam int AD = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]          start, reduce, busy, done, r_we;
    logic [1:0][AD-1:0]  out_len, a_addr, b_addr, r_raddr, r_waddr;
    logic [1:0][CW-1:0]  a_data, b_data;
    logic [1:0][AW-1:0]  r_rdata, r_wdata;

    logic [CW-1:0] a_mem [2][16];
    logic [CW-1:0] b_mem [2][16];
    logic [AW-1:0] r_mem [2][16];
    logic [1:0]          fill_req, fill_rand;
    logic [1:0][AW-1:0]  fill_val;

    int total = 0;
    int bad   = 0;
    int cyc [2];
    int wr [2];
    int jobs_done [2];
    int            exp_len_q [2][$];
    int            exp_lat_q [2][$];
    int            exp_wr_q  [2][$];
    logic [AW-1:0] exp_r_q   [2][$];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        poly_mac_engine #(.P(g == 0 ? 4 : 2), .CW(CW), .AW(AW), .ADDR_W(AD)) dut (
            .clk(clk), .rst(rst), .start(start[g]), .reduce(reduce[g]),
            .busy(busy[g]), .done(done[g]), .out_len(out_len[g]),
            .a_addr(a_addr[g]), .a_data(a_data[g]), .b_addr(b_addr[g]), .b_data(b_data[g]),
            .r_raddr(r_raddr[g]), .r_rdata(r_rdata[g]), .r_waddr(r_waddr[g]),
            .r_wdata(r_wdata[g]), .r_we(r_we[g])
        );
    end

    // Synchronous RAMs: 1-cycle read latency, read-first result RAM.
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            a_data[g]  <= a_mem[g][a_addr[g]];
            b_data[g]  <= b_mem[g][b_addr[g]];
            r_rdata[g] <= r_mem[g][r_raddr[g]];
            if (fill_req[g]) begin
                for (int k = 0; k < 16; k++)
                    r_mem[g][k] <= fill_rand[g] ? AW'($urandom) : fill_val[g];
            end else if (r_we[g]) begin
                r_mem[g][r_waddr[g]] <= r_wdata[g];
            end
        end
    end

    function automatic void chk(input string nm, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", nm, act, req);
        end
    endfunction

    always @(negedge clk) begin
        int len, lat, nwr;
        logic [AW-1:0] rv;
        for (int g = 0; g < 2; g++) begin
            if (rst) begin
                chk($sformatf("reset_busy[%0d]", g), busy[g], 0);
                chk($sformatf("reset_done[%0d]", g), done[g], 0);
                chk($sformatf("reset_we[%0d]", g), r_we[g], 0);
                chk($sformatf("reset_len[%0d]", g), out_len[g], 0);
                chk($sformatf("reset_addr[%0d]", g), {a_addr[g], b_addr[g], r_raddr[g], r_waddr[g]}, 0);
                chk($sformatf("reset_wdata[%0d]", g), r_wdata[g], 0);
                cyc[g] = 0;
                wr[g]  = 0;
            end else begin
                chk($sformatf("we_outside_busy[%0d]", g), r_we[g] & ~busy[g], 0);
                if (busy[g]) cyc[g]++;
                if (r_we[g]) wr[g]++;
                if (done[g]) begin
                    chk($sformatf("pending_job[%0d]", g), exp_len_q[g].size() > 0, 1);
                    if (exp_len_q[g].size() > 0) begin
                        len = exp_len_q[g].pop_front();
                        lat = exp_lat_q[g].pop_front();
                        nwr = exp_wr_q[g].pop_front();
                        chk($sformatf("out_len[%0d]", g), out_len[g], len);
                        chk($sformatf("latency[%0d]", g), cyc[g], lat);
                        chk($sformatf("writes[%0d]", g), wr[g], nwr);
                        for (int k = 0; k < len; k++) begin
                            rv = exp_r_q[g].pop_front();
                            chk($sformatf("r%0d[%0d]", g, k),
                                longint'($signed(r_mem[g][k])), longint'($signed(rv)));
                        end
                    end
                    jobs_done[g]++;
                    cyc[g] = 0;
                    wr[g]  = 0;
                end
            end
        end
    end

    // Reference: plain polynomial product, then x^P = x + 1 substitution, wrap to AW bits.
    task automatic push_expect(input int g, input bit red);
        int p = (g == 0) ? 4 : 2;
        longint acc [8];
        int len;
        foreach (acc[k]) acc[k] = 0;
        for (int i = 0; i < p; i++)
            for (int j = 0; j < p; j++)
                acc[i+j] += longint'($signed(a_mem[g][i])) * longint'($signed(b_mem[g][j]));
        if (red)
            for (int k = 2*p-2; k >= p; k--) begin
                acc[k-p]   += acc[k];
                acc[k-p+1] += acc[k];
            end
        len = red ? p : 2*p-1;
        exp_len_q[g].push_back(len);
        exp_lat_q[g].push_back(2 + (2*p-1) + p*p + (red ? 4*(p-1) : 0));
        exp_wr_q[g].push_back((2*p-1) + p*p + (red ? 2*(p-1) : 0));
        for (int k = 0; k < len; k++) exp_r_q[g].push_back(acc[k][AW-1:0]);
    endtask

    task automatic set_coefs(input int g, input int av [4], input int bv [4]);
        for (int i = 0; i < 16; i++) begin
            a_mem[g][i] = (i < 4) ? CW'(av[i]) : '0;
            b_mem[g][i] = (i < 4) ? CW'(bv[i]) : '0;
        end
    endtask

    task automatic wait_done(input int g);
        int n = jobs_done[g];
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            if (jobs_done[g] != n) return;
        end
        $display("FAIL job_timeout[%0d]: got no done in 3000 cycles, required a done pulse", g);
        $fatal(1, "job did not complete");
    endtask

    task automatic run_job(input int g, input bit red, input bit rnd_fill,
                           input logic [AW-1:0] fv, input int poke, input int abort);
        int len;
        #1;
        fill_rand[g] = rnd_fill;
        fill_val[g]  = fv;
        fill_req[g]  = 1'b1;
        @(posedge clk); #1;
        fill_req[g] = 1'b0;
        push_expect(g, red);
        start[g]  = 1'b1;
        reduce[g] = red;
        @(posedge clk); #1;
        start[g]  = 1'b0;
        reduce[g] = 1'($urandom);
        if (abort > 0) begin
            repeat (abort - 1) @(posedge clk);
            #2 rst = 1'b1;
            len = exp_len_q[g].pop_back();
            void'(exp_lat_q[g].pop_back());
            void'(exp_wr_q[g].pop_back());
            repeat (len) void'(exp_r_q[g].pop_back());
            repeat (3) @(posedge clk);
            #1 rst = 1'b0;
            return;
        end
        if (poke > 0) begin
            repeat (poke - 1) @(posedge clk);
            #1;
            start[g]  = 1'b1;
            reduce[g] = ~red;
            @(posedge clk); #1;
            start[g] = 1'b0;
        end
        wait_done(g);
    endtask

    initial begin
        int p;
        start = '0; reduce = '0; fill_req = '0; fill_rand = '0; fill_val = '0;
        for (int g = 0; g < 2; g++) begin
            jobs_done[g] = 0; cyc[g] = 0; wr[g] = 0;
            for (int i = 0; i < 16; i++) begin
                a_mem[g][i] = '0; b_mem[g][i] = '0;
            end
        end
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        set_coefs(0, '{1, 2, 0, 0}, '{3, 4, 0, 0});
        run_job(0, 1'b0, 1'b1, '0, 0, 0);
        set_coefs(0, '{0, 0, 0, 1}, '{0, 0, 0, 1});
        run_job(0, 1'b1, 1'b1, '0, 0, 0);
        set_coefs(0, '{-4096, -4096, -4096, -4096}, '{-4096, -4096, -4096, -4096});
        run_job(0, 1'b0, 1'b1, '0, 0, 0);
        set_coefs(0, '{5, 0, 0, 0}, '{-7, 0, 0, 0});
        run_job(0, 1'b0, 1'b0, AW'(26'h155), 0, 0);

        set_coefs(0, '{100, -200, 300, -400}, '{7, 8, -9, 10});
        run_job(0, 1'b0, 1'b1, '0, 0, 15);
        run_job(0, 1'b1, 1'b1, '0, 0, 0);
        set_coefs(0, '{3, -1, 4, -1}, '{5, 9, -2, 6});
        run_job(0, 1'b0, 1'b1, '0, 10, 0);
        run_job(0, 1'b1, 1'b1, '0, 12, 0);

        for (int n = 0; n < 12; n++) begin
            int g = n % 2;
            p = (g == 0) ? 4 : 2;
            for (int i = 0; i < 16; i++) begin
                case ($urandom_range(3))
                    0:       a_mem[g][i] = (i < p) ? 13'h1000 : '0;
                    1:       a_mem[g][i] = (i < p) ? 13'h0fff : '0;
                    default: a_mem[g][i] = (i < p) ? CW'($urandom) : '0;
                endcase
                b_mem[g][i] = (i < p) ? CW'($urandom) : '0;
            end
            run_job(g, 1'((n / 2) % 2), 1'b1, '0, 0, 0);
        end

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
